// File: rtl/mult_div_unit.sv
// Iterative signed/unsigned multiply and restoring divide producing a HI/LO pair.
// One operation per start pulse; results and handshake outputs are registered.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q;
  logic               is_div_q;
  logic               neg_q_q;
  logic               neg_r_q;
  logic               dz_flag_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   rem_q;
  logic [2*WIDTH-1:0] res_q;
  logic               busy_q, done_q, div_zero_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               signed_op;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               accept;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     rem_diff;
  logic               q_bit;
  logic [2*WIDTH-1:0] fix_res;
  logic [WIDTH-1:0]   quo, rem;

  assign signed_op = ~op[0];
  assign mag_a     = (signed_op && a[WIDTH-1]) ? -a : a;
  assign mag_b     = (signed_op && b[WIDTH-1]) ? -b : b;
  assign accept    = (state_q == StIdle) && start;

  // Multiply: add the multiplicand into the upper half, then shift the pair right.
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);

  // Divide: W+1-bit trial remainder; the top bit of the difference is the borrow.
  assign rem_shift = {rem_q, acc_q[WIDTH-1]};
  assign rem_diff  = rem_shift - {1'b0, opnd_q};
  assign q_bit     = ~rem_diff[WIDTH];

  assign quo = acc_q[WIDTH-1:0];
  assign rem = rem_q;

  always_comb begin
    fix_res = '0;
    if (is_div_q) begin
      fix_res[WIDTH-1:0]       = neg_q_q ? -quo : quo;
      fix_res[2*WIDTH-1:WIDTH] = neg_r_q ? -rem : rem;
    end else begin
      fix_res = neg_q_q ? -acc_q : acc_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (start) state_d = (op[1] && (b == '0)) ? StDone : StCalc;
      StCalc: if (cnt_q == '0) state_d = StFix;
      StFix:  state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      dz_flag_q  <= 1'b0;
      opnd_q     <= '0;
      acc_q      <= '0;
      rem_q      <= '0;
      res_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q <= state_d;

      if (accept) begin
        is_div_q  <= op[1];
        neg_q_q   <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_r_q   <= signed_op & a[WIDTH-1];
        dz_flag_q <= op[1] & (b == '0);
        opnd_q    <= op[1] ? mag_b : mag_a;
        acc_q     <= {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
        rem_q     <= '0;
        cnt_q     <= CntW'(WIDTH - 1);
      end

      if (state_q == StCalc) begin
        cnt_q <= cnt_q - 1'b1;
        if (is_div_q) begin
          rem_q            <= q_bit ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
          acc_q[WIDTH-1:0] <= {acc_q[WIDTH-2:0], q_bit};
        end else begin
          acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
        end
      end

      if (state_q == StFix) res_q <= fix_res;

      // Handshake outputs trail the FSM by one edge so they come straight from flops.
      busy_q     <= (state_q == StCalc) || (state_q == StFix);
      done_q     <= (state_q == StDone);
      div_zero_q <= (state_q == StDone) && dz_flag_q;
      if ((state_q == StDone) && !dz_flag_q) begin
        hi_q <= res_q[2*WIDTH-1:WIDTH];
        lo_q <= res_q[WIDTH-1:0];
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed, table-driven bench for mult_div_unit at WIDTH=32 plus a WIDTH=8 instance.
module tb_mult_div_unit;

  localparam logic [1:0] OpMult  = 2'b00;
  localparam logic [1:0] OpMultu = 2'b01;
  localparam logic [1:0] OpDiv   = 2'b10;
  localparam logic [1:0] OpDivu  = 2'b11;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  logic        start8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, div_zero8;
  logic [7:0]  hi8, lo8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  mult_div_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .div_zero(div_zero8), .hi(hi8), .lo(lo8)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } vec_t;

  vec_t vecs[12];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  // Start an op at edge k, then report edges to done, busy-cycle count and outputs at done.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int lat, output int bcnt, output logic dz_o,
                        output logic [31:0] hi_o, output logic [31:0] lo_o,
                        output logic pulse_ok);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; bcnt = 0;
    while (!done && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy) bcnt++;
    end
    dz_o = div_zero; hi_o = hi; lo_o = lo;
    @(posedge clk);
    #1 pulse_ok = !done && !div_zero;
  endtask

  initial begin
    int          lat, bcnt;
    logic        dz_o, pulse_ok;
    logic [31:0] hi_o, lo_o;
    bit          seen;

    vecs[0]  = '{OpMult,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[1]  = '{OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[2]  = '{OpMult,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0};
    vecs[3]  = '{OpDiv,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[4]  = '{OpDivu,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    vecs[5]  = '{OpDivu,  32'd5,         32'd0,         32'd2,         32'd14,        1'b1};
    vecs[6]  = '{OpDiv,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[7]  = '{OpMultu, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0};
    vecs[8]  = '{OpDiv,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vecs[9]  = '{OpDivu,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0};
    vecs[10] = '{OpMult,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[11] = '{OpDiv,   32'd5,         32'd0,         32'h4000_0000, 32'h0000_0000, 1'b1};

    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {busy, done, div_zero, hi, lo}, '0);
    chk("reset_outputs8", {busy8, done8, div_zero8, hi8, lo8}, '0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcnt, dz_o, hi_o, lo_o, pulse_ok);
      chk($sformatf("v%0d_hi", i), hi_o, vecs[i].hi);
      chk($sformatf("v%0d_lo", i), lo_o, vecs[i].lo);
      chk($sformatf("v%0d_div_zero", i), dz_o, vecs[i].dz);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].dz ? 1 : 34);
      chk($sformatf("v%0d_busy_cycles", i), bcnt, vecs[i].dz ? 0 : 33);
      chk($sformatf("v%0d_one_cycle_pulse", i), pulse_ok, 1'b1);
    end

    // A second start with new operands mid-CALC must be ignored.
    @(negedge clk);
    start = 1'b1; op = OpMult; a = 32'hFFFF_FFFD; b = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      if (lat == 5) begin
        start = 1'b1; op = OpDivu; a = 32'd100; b = 32'd7;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    chk("midcalc_latency", lat, 34);
    chk("midcalc_hi", hi, 32'hFFFF_FFFF);
    chk("midcalc_lo", lo, 32'hFFFF_FFEB);
    @(posedge clk);
    #1 chk("midcalc_no_requeue", {done, busy}, 2'b00);

    // Reset at edge k+10 discards the in-flight divide.
    @(negedge clk);
    start = 1'b1; op = OpDivu; a = 32'd100; b = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 chk("midrun_reset_outputs", {busy, done, div_zero, hi, lo}, '0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1 if (done || busy) seen = 1'b1;
    end
    chk("midrun_reset_no_done", seen, 1'b0);

    // Signed divide on the 8-bit instance.
    @(negedge clk);
    start8 = 1'b1; op8 = OpDiv; a8 = 8'hF9; b8 = 8'h02;
    @(posedge clk);
    #1 start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("w8_latency", lat, 10);
    chk("w8_lo", lo8, 8'hFD);
    chk("w8_hi", hi8, 8'hFF);
    chk("w8_div_zero", div_zero8, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Parametrised iterative multiply/divide unit that produces the HI/LO register pair for the multicycle CPU datapath. It accepts one operation per start pulse, runs a shift-add or restoring-divide loop over WIDTH cycles, and then loads hi/lo. It raises a done pulse for the control FSM and reports division by zero, which drives the DIV_ZERO exception path. Unlike the fixed HI/LO sources in the current datapath, it is width-generic, supports signed and unsigned modes, and exposes an explicit busy/done handshake.

## Interface
- WIDTH, 32, operand width; even, >= 4; hi and lo are each WIDTH bits
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU; sampled with start
- a  input  WIDTH  multiplicand / dividend; sampled with start
- b  input  WIDTH  multiplier / divisor; sampled with start
- busy  output  1  high while an operation is in flight (CALC, FIX)
- done  output  1  one-cycle pulse; hi/lo are final in the same cycle
- div_zero  output  1  one-cycle pulse coincident with done; set only for a DIV/DIVU with b == 0
- hi  output  WIDTH  MULT: upper product half; DIV: remainder
- lo  output  WIDTH  MULT: lower product half; DIV: quotient

## Operation
- States: IDLE, CALC, FIX, DONE.
- Reset state: IDLE. Outputs: hi=0, lo=0, busy=0, done=0, div_zero=0. Internal counter and accumulators are cleared.
- IDLE, start=1:
  - Latch op.
  - For signed ops, latch |a| and |b|, plus the result-sign flags: sign_q = a[W-1]^b[W-1]; sign_r = a[W-1].
  - Unsigned ops latch the raw operands.
  - If op is DIV/DIVU and b==0, go to DONE with div_zero flagged. Otherwise go to CALC with the counter = WIDTH-1.
- CALC, one iteration per cycle, WIDTH iterations total:
  - Multiply: 2W-bit accumulator, radix-2 shift-add.
  - Divide: restoring, 1 quotient bit per cycle. Partial remainder is W+1 bits.
  - Counter decrements each cycle. At 0, go to FIX.
- FIX:
  - Apply sign correction. Signed product is negated if sign_q. Signed quotient is negated if sign_q. Signed remainder is negated if sign_r.
  - Division truncates toward zero.
  - MULTU/DIVU pass through unchanged.
  - Go to DONE.
- DONE:
  - Loads hi/lo from the corrected result, except on div_zero, where hi/lo keep their previous values.
  - done=1 for this cycle; div_zero=1 if flagged.
  - Next state: IDLE.
- Arithmetic:
  - Negation is two's complement modulo 2^(2W) for products and modulo 2^W for quotient/remainder.
  - DIV of most-negative by -1 wraps: lo=most-negative, hi=0. No overflow flag.
- start while busy or in DONE: ignored. Operands are not re-sampled and there is no queueing.
- hi/lo hold their values between operations and change only in DONE (or on reset).
- Reset asserted in any state: on the next edge go to IDLE with all outputs at their reset values. An in-flight result is discarded and done does not pulse.

## Timing
- Define start sampled at edge k.
- busy=1 for the cycles after edges k+1 … k+WIDTH+1 (CALC for WIDTH cycles, then FIX). Otherwise busy=0.
- done/div_zero go high after edge k+WIDTH+2 and last one cycle; hi/lo update at that edge. Latency = WIDTH+2 cycles.
- Divide-by-zero path: done=div_zero=1 after edge k+1; busy stays 0.
- Back-to-back: the earliest new start is sampled at the edge that leaves DONE (edge k+WIDTH+3). Throughput is one operation per WIDTH+3 cycles.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Signed multiply, WIDTH=32: MULT a=0xFFFFFFFD (-3), b=7. Required: done at edge k+34 with hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for 33 cycles.
- Unsigned multiply extreme: MULTU a=b=0xFFFFFFFF. Required: hi=0xFFFFFFFE, lo=0x00000001. Then MULT on the same operands. Required: hi=0, lo=1.
- Signed divide: DIV a=0xFFFFFFF9 (-7), b=2. Required: lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Then DIVU a=100, b=7. Required: lo=14, hi=2.
- Divide by zero: preload hi=2, lo=14, then DIVU a=5, b=0. Required: after edge k+1, done=div_zero=1 for one cycle; hi/lo stay 2/14; busy never asserts.
- Wrap case: DIV a=0x80000000, b=0xFFFFFFFF. Required: lo=0x80000000, hi=0, div_zero=0.
- Handshake/reset:
  - A start pulse with new operands mid-CALC is ignored, and the original result is delivered at edge k+34.
  - Second run: assert reset at edge k+10. Required: IDLE, hi=lo=0, and no done pulse within 40 cycles.
  - Repeat the signed-divide check with WIDTH=8 (DIV 0xF9 / 0x02). Required: lo=0xFD, hi=0xFF, done at edge k+10.
